// File: rtl/countdown_arbiter.sv
// rtl/countdown_arbiter.sv - round-robin arbiter sharing one down counter between requesters
//
// Purpose:
//   One WIDTH-bit down counter is shared by N_REQ requesters. A round-robin
//   arbiter picks the next requester, loads its start value, counts down to
//   zero and returns a one-cycle done pulse to that requester. Used for shared
//   delay/timeout generation above the down-counter datapath.
//
// Optional feature (compile-time):
//   COUNTDOWN_ARBITER_AUTORELOAD_EN - when defined, a lone requester that keeps
//   its request high is reloaded straight from DONE back into COUNT. Grant stays
//   high and there is no IDLE gap, giving a periodic done every V+2 cycles.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   req       in   [N_REQ-1:0]        level request per requester
//   load_val  in   [N_REQ*WIDTH-1:0]  start value, slice [i*WIDTH +: WIDTH] = requester i
//   abort     in   cancels the countdown in progress (ignored in IDLE/DONE)
//   grant     out  [N_REQ-1:0]        one-hot owner, zero when idle
//   busy      out  high whenever the sequencer is not IDLE
//   count     out  [WIDTH-1:0]        current counter value
//   done      out  [N_REQ-1:0]        one-cycle completion pulse to the owner

module countdown_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] load_val,
  input  logic                   abort,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy,
  output logic [WIDTH-1:0]       count,
  output logic [N_REQ-1:0]       done
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic               busy_q, busy_d;

  logic [IDX_W-1:0]   winner;
  logic               win_valid;
  logic [IDX_W:0]     search_sum;
  logic [IDX_W-1:0]   search_idx;
  logic [N_REQ-1:0]   winner_onehot;
  logic [N_REQ-1:0]   owner_onehot;

`ifdef COUNTDOWN_ARBITER_AUTORELOAD_EN
  logic [N_REQ-1:0]   other_req;
`endif

  // Round-robin search: candidates are rr_ptr+1, rr_ptr+2, ... modulo N_REQ.
  // The loop runs from the farthest candidate to the nearest so the nearest
  // requesting candidate is the last assignment and therefore wins.
  always_comb begin
    winner     = rr_ptr_q;
    win_valid  = 1'b0;
    search_sum = '0;
    search_idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      search_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (search_sum >= (IDX_W+1)'(N_REQ)) begin
        search_sum = search_sum - (IDX_W+1)'(N_REQ);
      end
      search_idx = search_sum[IDX_W-1:0];
      if (req[search_idx]) begin
        winner    = search_idx;
        win_valid = 1'b1;
      end
    end
  end

  always_comb begin
    winner_onehot         = '0;
    winner_onehot[winner] = 1'b1;
    owner_onehot          = '0;
    owner_onehot[owner_q] = 1'b1;
  end

`ifdef COUNTDOWN_ARBITER_AUTORELOAD_EN
  assign other_req = req & ~owner_onehot;
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    count_d  = count_q;
    done_d   = '0;
    busy_d   = busy_q;

    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = COUNT;
          owner_d = winner;
          grant_d = winner_onehot;
          count_d = load_val[int'(winner)*WIDTH +: WIDTH];
          busy_d  = 1'b1;
        end
      end

      COUNT: begin
        if (abort) begin
          // Cancelled owner drops to lowest priority, no done pulse.
          state_d  = IDLE;
          grant_d  = '0;
          count_d  = '0;
          rr_ptr_d = owner_q;
          busy_d   = 1'b0;
        end else if (count_q == '0) begin
          state_d = DONE;
          done_d  = owner_onehot;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end

      DONE: begin
`ifdef COUNTDOWN_ARBITER_AUTORELOAD_EN
        if (req[owner_q] && (other_req == '0)) begin
          // Lone requester still asking: restart without an IDLE gap.
          state_d = COUNT;
          count_d = load_val[int'(owner_q)*WIDTH +: WIDTH];
        end else begin
          state_d  = IDLE;
          grant_d  = '0;
          count_d  = '0;
          rr_ptr_d = owner_q;
          busy_d   = 1'b0;
        end
`else
        state_d  = IDLE;
        grant_d  = '0;
        count_d  = '0;
        rr_ptr_d = owner_q;
        busy_d   = 1'b0;
`endif
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
        count_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= IDX_W'(N_REQ - 1);
      grant_q  <= '0;
      done_q   <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign count = count_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_countdown_arbiter.sv
// tb/tb_countdown_arbiter.sv - directed self-checking bench for countdown_arbiter

module tb_countdown_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] load_val;
  logic        abort;
  logic [3:0]  grant;
  logic        busy;
  logic [3:0]  count;
  logic [3:0]  done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  countdown_arbiter #(.N_REQ(4), .WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .load_val (load_val),
    .abort    (abort),
    .grant    (grant),
    .busy     (busy),
    .count    (count),
    .done     (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [3:0] d,
                            input logic [3:0] c, input logic b);
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".done"},  32'(done),  32'(d));
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".busy"},  32'(busy),  32'(b));
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = '0; load_val = '0; abort = 1'b0;
    step(); step();
    expect_out("reset", 4'b0000, 4'b0000, 4'd0, 1'b0);
    rst = 1'b0;

    // Async reset mid-countdown
    req = 4'b0001; load_val = 16'h0005;
    step(); expect_out("rst_pre0", 4'b0001, 4'b0000, 4'd5, 1'b1);
    step(); expect_out("rst_pre1", 4'b0001, 4'b0000, 4'd4, 1'b1);
    #2 rst = 1'b1;
    #1 expect_out("rst_async", 4'b0000, 4'b0000, 4'd0, 1'b0);
    step(); expect_out("rst_hold", 4'b0000, 4'b0000, 4'd0, 1'b0);
    step(); rst = 1'b0; req = '0;
    step(); expect_out("rst_rel", 4'b0000, 4'b0000, 4'd0, 1'b0);

    // Round robin, all requesting, all values 1
    req = 4'b1111; load_val = 16'h1111;
    for (int g = 0; g < 5; g++) begin
      logic [3:0] oh;
      oh = 4'b0001 << (g % 4);
      step(); expect_out($sformatf("rr%0d_c1", g), oh, 4'b0000, 4'd1, 1'b1);
      step(); expect_out($sformatf("rr%0d_c0", g), oh, 4'b0000, 4'd0, 1'b1);
      step(); expect_out($sformatf("rr%0d_dn", g), oh, oh, 4'd0, 1'b1);
      if (g == 4) req = '0;
      step(); expect_out($sformatf("rr%0d_id", g), 4'b0000, 4'b0000, 4'd0, 1'b0);
    end

    // Single request, value 3; changes during COUNT ignored
    req = 4'b0100; load_val = 16'h0300;
    step(); expect_out("single_g", 4'b0100, 4'b0000, 4'd3, 1'b1);
    req = '0; load_val = 16'h0F00;
    step(); expect_out("single_2", 4'b0100, 4'b0000, 4'd2, 1'b1);
    step(); expect_out("single_1", 4'b0100, 4'b0000, 4'd1, 1'b1);
    step(); expect_out("single_0", 4'b0100, 4'b0000, 4'd0, 1'b1);
    step(); expect_out("single_dn", 4'b0100, 4'b0100, 4'd0, 1'b1);
    step(); expect_out("single_id", 4'b0000, 4'b0000, 4'd0, 1'b0);

    // Zero start value
    req = 4'b0010; load_val = 16'h0000;
    step(); expect_out("zero_g", 4'b0010, 4'b0000, 4'd0, 1'b1);
    req = '0;
    step(); expect_out("zero_dn", 4'b0010, 4'b0010, 4'd0, 1'b1);
    step(); expect_out("zero_id", 4'b0000, 4'b0000, 4'd0, 1'b0);

    // Abort at count 5, then requester 3 has lowest priority
    req = 4'b1000; load_val = 16'h9000;
    step(); expect_out("abort_g", 4'b1000, 4'b0000, 4'd9, 1'b1);
    for (int c = 8; c >= 5; c--) begin
      step(); expect_out($sformatf("abort_c%0d", c), 4'b1000, 4'b0000, 4'(c), 1'b1);
    end
    abort = 1'b1;
    step(); expect_out("abort_id", 4'b0000, 4'b0000, 4'd0, 1'b0);
    abort = 1'b0; req = 4'b1001; load_val = 16'h9001;
    step(); expect_out("abort_rr", 4'b0001, 4'b0000, 4'd1, 1'b1);
    req = '0;
    step(); expect_out("abort_rr0", 4'b0001, 4'b0000, 4'd0, 1'b1);
    step(); expect_out("abort_rrdn", 4'b0001, 4'b0001, 4'd0, 1'b1);
    step(); expect_out("abort_rrid", 4'b0000, 4'b0000, 4'd0, 1'b0);

    // Abort while IDLE has no effect on the grant
    abort = 1'b1; req = 4'b0100; load_val = 16'h0200;
    step(); expect_out("idleab_g", 4'b0100, 4'b0000, 4'd2, 1'b1);
    abort = 1'b0; req = '0;
    step(); expect_out("idleab_1", 4'b0100, 4'b0000, 4'd1, 1'b1);
    step(); expect_out("idleab_0", 4'b0100, 4'b0000, 4'd0, 1'b1);
    step(); expect_out("idleab_dn", 4'b0100, 4'b0100, 4'd0, 1'b1);
    step(); expect_out("idleab_id", 4'b0000, 4'b0000, 4'd0, 1'b0);

    // Full range value 15, no wrap
    req = 4'b0001; load_val = 16'h000F;
    step(); expect_out("full_g", 4'b0001, 4'b0000, 4'd15, 1'b1);
    req = '0;
    for (int c = 14; c >= 0; c--) begin
      step(); expect_out($sformatf("full_c%0d", c), 4'b0001, 4'b0000, 4'(c), 1'b1);
    end
    step(); expect_out("full_dn", 4'b0001, 4'b0001, 4'd0, 1'b1);
    step(); expect_out("full_id", 4'b0000, 4'b0000, 4'd0, 1'b0);

    // Lone requester held high: autoreload or IDLE gap depending on build
    req = 4'b0001; load_val = 16'h0002;
    step(); expect_out("lone_g", 4'b0001, 4'b0000, 4'd2, 1'b1);
    step(); expect_out("lone_1", 4'b0001, 4'b0000, 4'd1, 1'b1);
    step(); expect_out("lone_0", 4'b0001, 4'b0000, 4'd0, 1'b1);
    step(); expect_out("lone_dn", 4'b0001, 4'b0001, 4'd0, 1'b1);
`ifdef COUNTDOWN_ARBITER_AUTORELOAD_EN
    step(); expect_out("auto_r2", 4'b0001, 4'b0000, 4'd2, 1'b1);
    step(); expect_out("auto_r1", 4'b0001, 4'b0000, 4'd1, 1'b1);
    req = 4'b0011;
    step(); expect_out("auto_r0", 4'b0001, 4'b0000, 4'd0, 1'b1);
    step(); expect_out("auto_dn", 4'b0001, 4'b0001, 4'd0, 1'b1);
    step(); expect_out("auto_id", 4'b0000, 4'b0000, 4'd0, 1'b0);
    step(); expect_out("auto_g1", 4'b0010, 4'b0000, 4'd0, 1'b1);
    req = '0;
    step(); expect_out("auto_dn1", 4'b0010, 4'b0010, 4'd0, 1'b1);
    step(); expect_out("auto_id1", 4'b0000, 4'b0000, 4'd0, 1'b0);
`else
    step(); expect_out("gap_id", 4'b0000, 4'b0000, 4'd0, 1'b0);
    step(); expect_out("gap_g", 4'b0001, 4'b0000, 4'd2, 1'b1);
    req = '0;
    step(); expect_out("gap_1", 4'b0001, 4'b0000, 4'd1, 1'b1);
    step(); expect_out("gap_0", 4'b0001, 4'b0000, 4'd0, 1'b1);
    step(); expect_out("gap_dn", 4'b0001, 4'b0001, 4'd0, 1'b1);
    step(); expect_out("gap_id2", 4'b0000, 4'b0000, 4'd0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
